// File: rtl/mii_pkg.sv
// -----------------------------------------------------------------------------
// mii_pkg
// Shared types and constants for the MII transmit payload path.
//   tx_payload_state_e : payload buffer/serialiser state encoding
//   ETH_MIN_PAYLOAD    : payload length below which zero padding is added
//   ETH_MAX_PAYLOAD    : largest payload accepted
//   CRC32_*            : reflected Ethernet CRC32 constants
//   crc32_nib_step     : one 4-bit, LSB-first CRC32 update
// -----------------------------------------------------------------------------
package mii_pkg;

    typedef enum logic [2:0] {
        ST_FILL    = 3'd0,
        ST_READY   = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_PAD     = 3'd3,
        ST_FCS     = 3'd4,
        ST_DONE    = 3'd5
    } tx_payload_state_e;

    localparam int ETH_MIN_PAYLOAD = 46;
    localparam int ETH_MAX_PAYLOAD = 1500;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    // Register value left after running a frame plus its own FCS through the CRC.
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    // Feed four bits into the CRC, nibble bit 0 first (MII wire order).
    function automatic logic [31:0] crc32_nib_step(input logic [31:0] crc,
                                                   input logic [3:0]  nib);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 4; i++) begin
            if (c[0] ^ nib[i]) begin
                c = {1'b0, c[31:1]} ^ CRC32_POLY_REFL;
            end else begin
                c = {1'b0, c[31:1]};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_nib.sv
// -----------------------------------------------------------------------------
// crc32_nib
// Combinational single-nibble CRC32 step (reflected polynomial, LSB first).
// Ports:
//   crc_in  [31:0] : current CRC register
//   nib     [3:0]  : nibble to absorb, bit 0 first
//   crc_out [31:0] : updated CRC register
// -----------------------------------------------------------------------------
module crc32_nib
    import mii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [3:0]  nib,
    output logic [31:0] crc_out
);

    assign crc_out = crc32_nib_step(crc_in, nib);

endmodule

// File: rtl/mii_tx_payload.sv
// -----------------------------------------------------------------------------
// mii_tx_payload
// Buffers one Ethernet payload written as bytes, then streams it to the MII TX
// framer as nibbles (low nibble first) once the framer signals send_next.
// Short payloads are zero padded to MIN_PAYLOAD bytes. With MII_TX_FCS_EN
// defined, a CRC32 over the snooped header nibbles plus payload/pad nibbles is
// appended as 8 FCS nibbles; otherwise tx_nib/tx_nib_valid are ignored.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   wr_valid/data/last   : byte write interface, wr_ready = byte accepted
//   send_next            : framer level, header done -> drain payload
//   tx_nib, tx_nib_valid : header nibble snoop for the FCS
//   din_done             : complete frame buffered, held until drain ends
//   nib_out, nib_valid   : nibble stream to the framer
//   frame_end            : pulse with the last nibble of the frame
//   err                  : pulse when an oversize frame is dropped
// -----------------------------------------------------------------------------
module mii_tx_payload
    import mii_pkg::*;
#(
    parameter int DEPTH       = 2048,
    parameter int MIN_PAYLOAD = ETH_MIN_PAYLOAD,
    parameter int MAX_PAYLOAD = ETH_MAX_PAYLOAD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    input  logic       wr_last,
    output logic       wr_ready,
    input  logic       send_next,
    input  logic [3:0] tx_nib,
    input  logic       tx_nib_valid,
    output logic       din_done,
    output logic [3:0] nib_out,
    output logic       nib_valid,
    output logic       frame_end,
    output logic       err
);

    localparam int            AW    = $clog2(DEPTH);
    localparam logic [AW-1:0] MIN_L = AW'(MIN_PAYLOAD);
    localparam logic [AW-1:0] MAX_L = AW'(MAX_PAYLOAD);
`ifdef MII_TX_FCS_EN
    localparam bit            FCS_EN = 1'b1;
`else
    localparam bit            FCS_EN = 1'b0;
`endif

    tx_payload_state_e state_r;
    logic [AW-1:0]     len_r;
    logic [AW-1:0]     idx_r;
    logic              hi_r;
    logic              wr_ready_r;
    logic              din_done_r;
    logic [3:0]        nib_out_r;
    logic              nib_valid_r;
    logic              frame_end_r;
    logic              err_r;

    logic [7:0]        mem_r [DEPTH];
    logic              wr_en_s;
    logic [AW-1:0]     idx_inc_s;
    logic [AW-1:0]     rd_addr_s;
    logic [7:0]        rd_byte_s;
    logic              more_data_s;
    logic              more_pad_s;
    logic              last_byte_s;

    assign wr_en_s     = (state_r == ST_FILL) && wr_valid && wr_ready_r && (len_r != MAX_L);
    assign idx_inc_s   = idx_r + 1'b1;
    // While the high nibble is on the wire, look ahead to the next byte.
    assign rd_addr_s   = hi_r ? idx_inc_s : idx_r;
    assign rd_byte_s   = mem_r[rd_addr_s];
    assign more_data_s = (idx_inc_s < len_r);
    assign more_pad_s  = (idx_inc_s < MIN_L);
    assign last_byte_s = !more_data_s && !more_pad_s;

`ifdef MII_TX_FCS_EN
    logic [31:0] crc_r;
    logic [31:0] crc_data_s;
    logic [31:0] crc_snoop_s;
    logic [31:0] fcs_s;
    logic [27:0] fcs_sr_r;
    logic [2:0]  fcs_cnt_r;

    crc32_nib u_crc_data (
        .crc_in  (crc_r),
        .nib     (nib_out_r),
        .crc_out (crc_data_s)
    );

    crc32_nib u_crc_snoop (
        .crc_in  (crc_r),
        .nib     (tx_nib),
        .crc_out (crc_snoop_s)
    );

    // FCS includes the nibble currently on the wire, hence crc_data_s.
    assign fcs_s = ~crc_data_s;

    // CRC accumulator: emitted payload/pad nibbles take priority over header snoop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_r <= CRC32_INIT;
        end else if (state_r == ST_FILL) begin
            crc_r <= CRC32_INIT;
        end else if ((state_r == ST_PAYLOAD) || (state_r == ST_PAD)) begin
            crc_r <= crc_data_s;
        end else if (tx_nib_valid) begin
            crc_r <= crc_snoop_s;
        end else begin
            crc_r <= crc_r;
        end
    end
`else
    logic unused_snoop_s;
    assign unused_snoop_s = ^{tx_nib, tx_nib_valid};
`endif

    // Payload buffer write port; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[len_r] <= wr_data;
        end
    end

    // Control FSM: fill, drain sequencing and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_FILL;
            len_r       <= '0;
            idx_r       <= '0;
            hi_r        <= 1'b0;
            wr_ready_r  <= 1'b0;
            din_done_r  <= 1'b0;
            nib_out_r   <= 4'h0;
            nib_valid_r <= 1'b0;
            frame_end_r <= 1'b0;
            err_r       <= 1'b0;
`ifdef MII_TX_FCS_EN
            fcs_sr_r    <= '0;
            fcs_cnt_r   <= 3'd0;
`endif
        end else begin
            err_r       <= 1'b0;
            frame_end_r <= 1'b0;
            case (state_r)
                ST_FILL: begin
                    wr_ready_r <= 1'b1;
                    if (wr_valid && wr_ready_r) begin
                        if (len_r == MAX_L) begin
                            // Oversize: drop everything buffered and start over.
                            err_r <= 1'b1;
                            len_r <= '0;
                        end else begin
                            len_r <= len_r + 1'b1;
                            if (wr_last) begin
                                state_r    <= ST_READY;
                                wr_ready_r <= 1'b0;
                                din_done_r <= 1'b1;
                                idx_r      <= '0;
                                hi_r       <= 1'b0;
                            end
                        end
                    end
                end
                ST_READY: begin
                    if (send_next) begin
                        state_r     <= ST_PAYLOAD;
                        nib_out_r   <= rd_byte_s[3:0];
                        nib_valid_r <= 1'b1;
                    end
                end
                ST_PAYLOAD, ST_PAD: begin
                    if (!hi_r) begin
                        hi_r        <= 1'b1;
                        nib_out_r   <= (state_r == ST_PAYLOAD) ? rd_byte_s[7:4] : 4'h0;
                        frame_end_r <= last_byte_s && !FCS_EN;
                    end else if (more_data_s) begin
                        idx_r     <= idx_inc_s;
                        hi_r      <= 1'b0;
                        nib_out_r <= rd_byte_s[3:0];
                    end else if (more_pad_s) begin
                        state_r   <= ST_PAD;
                        idx_r     <= idx_inc_s;
                        hi_r      <= 1'b0;
                        nib_out_r <= 4'h0;
                    end else begin
`ifdef MII_TX_FCS_EN
                        state_r   <= ST_FCS;
                        nib_out_r <= fcs_s[3:0];
                        fcs_sr_r  <= fcs_s[31:4];
                        fcs_cnt_r <= 3'd0;
`else
                        state_r     <= ST_DONE;
                        nib_out_r   <= 4'h0;
                        nib_valid_r <= 1'b0;
                        din_done_r  <= 1'b0;
`endif
                    end
                end
`ifdef MII_TX_FCS_EN
                ST_FCS: begin
                    if (fcs_cnt_r == 3'd7) begin
                        state_r     <= ST_DONE;
                        nib_out_r   <= 4'h0;
                        nib_valid_r <= 1'b0;
                        din_done_r  <= 1'b0;
                    end else begin
                        nib_out_r   <= fcs_sr_r[3:0];
                        fcs_sr_r    <= {4'h0, fcs_sr_r[27:4]};
                        fcs_cnt_r   <= fcs_cnt_r + 3'd1;
                        frame_end_r <= (fcs_cnt_r == 3'd6);
                    end
                end
`endif
                ST_DONE: begin
                    // Wait for send_next to fall so one request never sends twice.
                    if (!send_next) begin
                        state_r    <= ST_FILL;
                        wr_ready_r <= 1'b1;
                        len_r      <= '0;
                        idx_r      <= '0;
                        hi_r       <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_FILL;
                    len_r       <= '0;
                    idx_r       <= '0;
                    hi_r        <= 1'b0;
                    wr_ready_r  <= 1'b0;
                    din_done_r  <= 1'b0;
                    nib_out_r   <= 4'h0;
                    nib_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready  = wr_ready_r;
    assign din_done  = din_done_r;
    assign nib_out   = nib_out_r;
    assign nib_valid = nib_valid_r;
    assign frame_end = frame_end_r;
    assign err       = err_r;

endmodule
